mem_wb_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline register.
- Sits directly downstream of the EXE/MEM register. Consumes its control and data outputs and performs loads and stores to data memory over a req/ack handshake.
- Stalls the upstream pipeline until the access completes, then registers the write-back value, destination and error status for the WB stage.

---
 rtl/mem_wb_stage_if.sv | 29 ++
 rtl/mem_wb_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// mem_wb_stage_if : data-memory req/ack bus between the MEM stage and memory
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_wb_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : memory-access stage with MEM/WB pipeline register
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  mem_alu_result,
  input  logic [DATA_W-1:0]  mem_sw_o,
  input  logic [DATA_W-1:0]  mem_write_o,
  input  logic               mem_lwsrc,
  input  logic               mem_movsrc,
  input  logic               mem_DM_read,
  input  logic               mem_DM_write,
  input  logic               mem_wreg,
  input  logic [RADDR_W-1:0] mem_wd,
  input  logic               flush,
  mem_wb_stage_if.master     dm,
  output logic               stall_req,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_wreg,
  output logic [RADDR_W-1:0] wb_wd,
  output logic               wb_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                discard_q, discard_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;
  logic                wb_wreg_q, wb_wreg_d;
  logic [RADDR_W-1:0]  wb_wd_q, wb_wd_d;
  logic                wb_err_q, wb_err_d;

  logic                w_access;
  logic                w_bad;
  logic                w_discard;
  logic                w_stall;
  logic [DATA_W-1:0]   w_result;

  assign w_access  = mem_DM_read | mem_DM_write;
  assign w_bad     = (w_access & (mem_alu_result[1:0] != 2'b00)) |
                     (mem_DM_read & mem_DM_write);
  assign w_discard = discard_q | flush;
  assign w_result  = mem_lwsrc  ? dm.dm_rdata :
                     mem_movsrc ? mem_write_o : DATA_W'(mem_alu_result);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_wdata_d = w_result;
    wb_wreg_d  = 1'b0;
    wb_wd_d    = mem_wd;
    wb_err_d   = 1'b0;
    w_stall    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A flush squashes the instruction before it can fault or issue.
        if (flush) begin
          wb_wreg_d = 1'b0;
        end else if (w_bad) begin
          wb_err_d = 1'b1;
        end else if (w_access) begin
          w_stall   = 1'b1;
          req_d     = 1'b1;
          we_d      = mem_DM_write;
          addr_d    = mem_alu_result;
          wdata_d   = mem_sw_o;
          cnt_d     = '0;
          discard_d = 1'b0;
          state_d   = S_ACCESS;
        end else begin
          wb_wreg_d = mem_wreg;
        end
      end

      S_ACCESS: begin
        if (dm.dm_ack) begin
          wb_wreg_d = mem_wreg & ~w_discard;
          req_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == C_LAST) begin
          wb_err_d  = ~w_discard;
          req_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          // Bus transactions are never aborted; a flush only marks the result for discard.
          w_stall   = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          discard_d = w_discard;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_wdata_q <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wd_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_wdata_q <= wb_wdata_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wd_q    <= wb_wd_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign stall_req   = rst & w_stall;
  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign wb_wdata    = wb_wdata_q;
  assign wb_wreg     = wb_wreg_q;
  assign wb_wd       = wb_wd_q;
  assign wb_err      = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : directed and randomized checks of mem_wb_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RW  = 5;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] mem_alu_result = '0;
  logic [DW-1:0] mem_sw_o = '0;
  logic [DW-1:0] mem_write_o = '0;
  logic          mem_lwsrc = 1'b0;
  logic          mem_movsrc = 1'b0;
  logic          mem_DM_read = 1'b0;
  logic          mem_DM_write = 1'b0;
  logic          mem_wreg = 1'b0;
  logic [RW-1:0] mem_wd = '0;
  logic          flush = 1'b0;
  logic          stall_req;
  logic [DW-1:0] wb_wdata;
  logic          wb_wreg;
  logic [RW-1:0] wb_wd;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(AW), .DATA_W(DW)) dm_if ();

  mem_wb_stage #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .RADDR_W(RW),
    .TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_alu_result(mem_alu_result),
    .mem_sw_o      (mem_sw_o),
    .mem_write_o   (mem_write_o),
    .mem_lwsrc     (mem_lwsrc),
    .mem_movsrc    (mem_movsrc),
    .mem_DM_read   (mem_DM_read),
    .mem_DM_write  (mem_DM_write),
    .mem_wreg      (mem_wreg),
    .mem_wd        (mem_wd),
    .flush         (flush),
    .dm            (dm_if),
    .stall_req     (stall_req),
    .wb_wdata      (wb_wdata),
    .wb_wreg       (wb_wreg),
    .wb_wd         (wb_wd),
    .wb_err        (wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction through MEM. ack_k: ACCESS-cycle index of dm_ack (>=TMO means never).
  // flush_at: cycle index (0 = first/IDLE cycle) where flush is pulsed, -1 for none.
  task automatic do_instr(input string tag, input logic rd, input logic wr, input logic lw,
                          input logic mv, input logic wreg, input logic [RW-1:0] wd,
                          input logic [AW-1:0] alu, input logic [DW-1:0] swo,
                          input logic [DW-1:0] wro, input logic [DW-1:0] rdata,
                          input int ack_k, input int flush_at);
    logic          acc, bad, legal, tmo, flushed, done;
    int            c, exp_stall, n, j;
    logic [DW-1:0] exp_data;
    acc       = rd | wr;
    bad       = acc && ((alu[1:0] != 2'b00) || (rd && wr));
    legal     = acc && !bad && (flush_at != 0);
    c         = (ack_k < TMO) ? ack_k : TMO - 1;
    tmo       = (ack_k >= TMO);
    exp_stall = legal ? c + 1 : 0;
    flushed   = (flush_at == 0) || (legal && flush_at >= 1 && flush_at - 1 <= c);
    exp_data  = lw ? rdata : (mv ? wro : alu);

    mem_DM_read = rd;  mem_DM_write = wr;  mem_lwsrc = lw;  mem_movsrc = mv;
    mem_wreg = wreg;   mem_wd = wd;        mem_alu_result = alu;
    mem_sw_o = swo;    mem_write_o = wro;  dm_if.dm_rdata = rdata;
    n = 0; j = 0; done = 1'b0;
    while (!done && j < TMO + 4) begin
      flush        = (j == flush_at);
      dm_if.dm_ack = legal && (j == ack_k + 1);
      @(negedge clk);
      if (stall_req) n++; else done = 1'b1;
      if (j >= 1) begin
        chk({tag, "_req"},  64'(dm_if.dm_req), 64'(1'b1));
        chk({tag, "_we"},   64'(dm_if.dm_we), 64'(wr));
        chk({tag, "_addr"}, 64'(dm_if.dm_addr), 64'(alu));
        if (wr) chk({tag, "_wdat"}, 64'(dm_if.dm_wdata), 64'(swo));
      end
      @(posedge clk); #1;
      j++;
    end
    flush = 1'b0; dm_if.dm_ack = 1'b0;
    chk({tag, "_stalls"}, 64'(n), 64'(exp_stall));
    chk({tag, "_req_off"}, 64'(dm_if.dm_req), 64'(1'b0));
    if (flushed) begin
      chk({tag, "_wreg"}, 64'(wb_wreg), 64'(1'b0));
      chk({tag, "_err"},  64'(wb_err), 64'(1'b0));
    end else if (bad || tmo && legal) begin
      chk({tag, "_wreg"}, 64'(wb_wreg), 64'(1'b0));
      chk({tag, "_err"},  64'(wb_err), 64'(1'b1));
    end else begin
      chk({tag, "_wreg"}, 64'(wb_wreg), 64'(wreg));
      chk({tag, "_err"},  64'(wb_err), 64'(1'b0));
      chk({tag, "_wd"},   64'(wb_wd), 64'(wd));
      if (!wr) chk({tag, "_wdata"}, 64'(wb_wdata), 64'(exp_data));
    end
  endtask

  initial begin
    logic          rd, wr, lw, mv;
    logic [AW-1:0] alu;
    int            sel, fa;
    dm_if.dm_ack = 1'b0;
    dm_if.dm_rdata = '0;
    // Reset with a legal load presented: stall must stay low.
    mem_DM_read = 1'b1; mem_alu_result = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_req), 64'(1'b0));
    chk("rst_req",   64'(dm_if.dm_req), 64'(1'b0));
    chk("rst_wb",    64'({wb_wdata, wb_wreg, wb_wd, wb_err}), 64'(0));
    mem_DM_read = 1'b0; mem_alu_result = '0;
    rst = 1'b1;
    @(posedge clk); #1;

    do_instr("alu",   0, 0, 0, 0, 1, 5'd3, 32'h1234, 0, 32'hBEEF, 0, 0, -1);
    do_instr("mov",   0, 0, 0, 1, 1, 5'd3, 32'h1234, 0, 32'hBEEF, 0, 0, -1);
    do_instr("load3", 1, 0, 1, 0, 1, 5'd5, 32'h40, 0, 0, 32'hCAFEF00D, 2, -1);
    do_instr("store", 0, 1, 0, 0, 0, 5'd0, 32'h80, 32'hA5A5A5A5, 0, 0, 0, -1);
    do_instr("b2bld", 1, 0, 1, 0, 1, 5'd7, 32'h84, 0, 0, 32'h13572468, 0, -1);
    do_instr("misal", 1, 0, 1, 0, 1, 5'd2, 32'h42, 0, 0, 0, 0, -1);
    do_instr("illeg", 1, 1, 0, 0, 1, 5'd2, 32'h44, 0, 0, 0, 0, -1);
    do_instr("after", 0, 0, 0, 0, 1, 5'd9, 32'h55, 0, 0, 0, 0, -1);
    do_instr("tmo",   1, 0, 1, 0, 1, 5'd4, 32'h48, 0, 0, 32'h1, TMO + 3, -1);
    do_instr("flush", 1, 0, 1, 0, 1, 5'd6, 32'h4C, 0, 0, 32'h2, 2, 2);
    do_instr("flid",  1, 0, 1, 0, 1, 5'd6, 32'h50, 0, 0, 32'h3, 0, 0);

    // Reset in the middle of an access; a late ack must be ignored.
    mem_DM_read = 1'b1; mem_lwsrc = 1'b1; mem_wreg = 1'b1; mem_wd = 5'd8;
    mem_alu_result = 32'h60;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("mrst_req", 64'(dm_if.dm_req), 64'(1'b0));
    chk("mrst_wb",  64'({wb_wdata, wb_wreg, wb_wd, wb_err}), 64'(0));
    chk("mrst_stall", 64'(stall_req), 64'(1'b0));
    mem_DM_read = 1'b0; mem_lwsrc = 1'b0; mem_wreg = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hDEAD;
    @(negedge clk);
    chk("late_ack_stall", 64'(stall_req), 64'(1'b0));
    @(posedge clk); #1;
    dm_if.dm_ack = 1'b0;
    chk("late_ack_req",  64'(dm_if.dm_req), 64'(1'b0));
    chk("late_ack_wreg", 64'(wb_wreg), 64'(1'b0));
    do_instr("postrst", 1, 0, 1, 0, 1, 5'd1, 32'h64, 0, 0, 32'h77, 1, -1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel >= 4 && sel <= 6) || sel == 9;
      wr  = (sel >= 7);
      lw  = rd && !wr && ($urandom_range(0, 3) != 0);
      mv  = 1'(($urandom & 1));
      alu = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
      fa  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 3)) : -1;
      do_instr("rnd", rd, wr, lw, mv, 1'(($urandom & 1)), RW'($urandom), alu,
               $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), fa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
